// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding.
package serial_subtractor_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_fs1bit.sv
// Combinational 1-bit full subtractor: d = a - b - br_in, with borrow out.
module fs1bit (
  input  logic a,
  input  logic b,
  input  logic br_in,
  output logic d,
  output logic br_out
);

  always_comb begin
    d      = a ^ b ^ br_in;
    br_out = (~a & b) | (~(a ^ b) & br_in);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock behind a start/done handshake.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic             br;
  logic             amsb;
  logic             bmsb;
  logic             d;
  logic             br_n;

  fs1bit u_fs (
    .a      (areg[0]),
    .b      (breg[0]),
    .br_in  (br),
    .d      (d),
    .br_out (br_n)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      areg  <= '0;
      breg  <= '0;
      br    <= 1'b0;
      amsb  <= 1'b0;
      bmsb  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            areg  <= a;
            breg  <= b;
            amsb  <= a[WIDTH-1];
            bmsb  <= b[WIDTH-1];
            br    <= 1'b0;
            cnt   <= '0;
            diff  <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        SHIFT: begin
          diff <= {d, diff[WIDTH-1:1]};
          areg <= areg >> 1;
          breg <= breg >> 1;
          br   <= br_n;
          // Counter parks at LAST instead of wrapping; it is cleared on the next start.
          if (cnt == LAST) begin
            bout  <= br_n;
            ovf   <= (amsb != bmsb) && (d != amsb);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed scoreboard bench for serial_subtractor at WIDTH = 8.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  exp_t sb[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int sx, sy, sd;
    sx = x[W-1] ? int'(x) - 256 : int'(x);
    sy = y[W-1] ? int'(y) - 256 : int'(y);
    sd = sx - sy;
    e.diff = W'((int'(x) - int'(y) + 256) % 256);
    e.bout = (int'(x) < int'(y));
    e.ovf  = (sd > 127) || (sd < -128);
    return e;
  endfunction

  // Monitor: pops the scoreboard on every done and checks busy/done exclusion.
  always @(negedge clk) begin
    if (busy && done) chk("busy_done_overlap", {busy, done}, 32'h0);
    if (done) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'h1, 32'h0);
      end else begin
        e = sb.pop_front();
        chk("diff", 32'(diff), 32'(e.diff));
        chk("bout", 32'(bout), 32'(e.bout));
        chk("ovf",  32'(ovf),  32'(e.ovf));
      end
    end
  end

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
    int n;
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    sb.push_back(model(x, y));
    n = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
    end while (!done && n < 40);
    chk({tag, "_latency"}, 32'(n), 32'(W + 1));
  endtask

  initial begin
    int n;
    int base;
    logic [W-1:0] pa [5];
    logic [W-1:0] pb [5];

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_diff", 32'(diff), 32'h0);
    chk("rst_bout_ovf", {bout, ovf}, 32'h0);
    rst = 1'b0;

    run_op(8'h5A, 8'h3C, "op5a3c");
    chk("hold_diff", 32'(diff), 32'h1E);
    run_op(8'h3C, 8'h5A, "op3c5a");
    run_op(8'h00, 8'h01, "op0001");
    run_op(8'h80, 8'h01, "op8001");
    run_op(8'h7F, 8'hFF, "op7fff");
    run_op(8'hFF, 8'hFF, "opffff");
    repeat (3) @(negedge clk);
    chk("idle_hold_diff", 32'(diff), 32'h00);
    chk("idle_busy", 32'(busy), 32'h0);

    // start pulsed mid-SHIFT must be ignored
    base = done_cnt;
    @(negedge clk);
    a = 8'h10; b = 8'h01; start = 1'b1;
    sb.push_back(model(8'h10, 8'h01));
    n = 0;
    do begin
      @(negedge clk);
      n++;
      start = (n == 3);
      if (n == 3) begin a = 8'hFF; b = 8'hFF; end
    end while (!done && n < 40);
    start = 1'b0;
    chk("ignore_latency", 32'(n), 32'(W + 1));
    repeat (12) @(negedge clk);
    chk("ignore_single_done", 32'(done_cnt - base), 32'h1);

    // back-to-back with start held high
    pa = '{8'h12, 8'h01, 8'hA0, 8'h00, 8'h7F};
    pb = '{8'h34, 8'h01, 8'h21, 8'h80, 8'h80};
    @(negedge clk);
    a = pa[0]; b = pb[0]; start = 1'b1;
    sb.push_back(model(pa[0], pb[0]));
    for (int i = 1; i <= 5; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!done && n < 40);
      chk("stream_period", 32'(n), 32'(W + 1));
      if (i < 5) begin
        a = pa[i]; b = pb[i];
        sb.push_back(model(pa[i], pb[i]));
      end else begin
        start = 1'b0;
      end
    end
    repeat (3) @(negedge clk);

    // reset in the middle of SHIFT aborts the operation
    @(negedge clk);
    a = 8'h55; b = 8'h22; start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
    end while (n < 4);
    chk("pre_rst_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_outs", {bout, ovf, 22'h0, diff}, 32'h0);
    base = done_cnt;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - base), 32'h0);
    run_op(8'hC3, 8'h3D, "post_rst");
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
